// File: rtl/ps2_kbmat.sv
// ps2_kbmat: PS/2 set-2 receiver maintaining the Z88 64-key matrix image; define PS2_KBMAT_PARITY_EN to enforce odd parity
module ps2_kbmat #(
   parameter int FILT_LEN    = 8,
   parameter int TIMEOUT_CYC = 19660
) (
   input  logic        mck,
   input  logic        rin_n,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   output logic [63:0] kbmat,
   output logic        code_stb,
   output logic [7:0]  code,
   output logic        frm_err
);
   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_KBMAT_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync, dat_sync;
   logic          clk_f, dat_f, fall;
   logic [FW-1:0] clk_cnt, dat_cnt;
   state_t        state, state_n;
   logic [2:0]    bitcnt, bitcnt_n;
   logic [7:0]    sr, sr_n, code_n;
   logic          odd, odd_n, stb_n, err_n, par_ok;
   logic [WW-1:0] wdog, wdog_n;
   logic          ext, brk, hit;
   logic [5:0]    idx;

   assign par_ok = odd || !PARITY_EN;

   // two-flop synchronisers, preset to the idle-high line level
   always_ff @(posedge mck or negedge rin_n)
      if (!rin_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
      end

   // glitch filters: a new level is accepted after FILT_LEN consecutive agreeing samples
   always_ff @(posedge mck or negedge rin_n)
      if (!rin_n) begin
         clk_f   <= 1'b1;
         dat_f   <= 1'b1;
         clk_cnt <= '0;
         dat_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_sync[1] == clk_f)
            clk_cnt <= '0;
         else if (clk_cnt == FW'(FILT_LEN - 1)) begin
            clk_f   <= clk_sync[1];
            clk_cnt <= '0;
            fall    <= clk_f;
         end else
            clk_cnt <= clk_cnt + 1'b1;
         if (dat_sync[1] == dat_f)
            dat_cnt <= '0;
         else if (dat_cnt == FW'(FILT_LEN - 1)) begin
            dat_f   <= dat_sync[1];
            dat_cnt <= '0;
         end else
            dat_cnt <= dat_cnt + 1'b1;
      end

   // frame sequencing on filtered clock falls; odd tracks parity of data plus parity bit
   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      sr_n     = sr;
      odd_n    = odd;
      code_n   = code;
      stb_n    = 1'b0;
      err_n    = 1'b0;
      wdog_n   = (state == IDLE || fall) ? '0 : wdog + 1'b1;
      if (fall)
         case (state)
            IDLE:
               if (!dat_f) begin
                  state_n  = DATA;
                  bitcnt_n = '0;
                  odd_n    = 1'b0;
               end
            DATA: begin
               sr_n     = {dat_f, sr[7:1]};
               odd_n    = odd ^ dat_f;
               bitcnt_n = bitcnt + 1'b1;
               state_n  = (bitcnt == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               odd_n   = odd ^ dat_f;
               state_n = STOP;
            end
            default: begin
               state_n = IDLE;
               stb_n   = dat_f && par_ok;
               err_n   = !(dat_f && par_ok);
               code_n  = (dat_f && par_ok) ? sr : code;
            end
         endcase
      else if (state != IDLE && wdog == WW'(TIMEOUT_CYC)) begin
         state_n  = IDLE;
         bitcnt_n = '0;
         err_n    = 1'b1;
         wdog_n   = '0;
      end
   end

   // frame state, watchdog and registered result strobes
   always_ff @(posedge mck or negedge rin_n)
      if (!rin_n) begin
         state    <= IDLE;
         bitcnt   <= '0;
         sr       <= '0;
         odd      <= 1'b0;
         wdog     <= '0;
         code     <= '0;
         code_stb <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         state    <= state_n;
         bitcnt   <= bitcnt_n;
         sr       <= sr_n;
         odd      <= odd_n;
         wdog     <= wdog_n;
         code     <= code_n;
         code_stb <= stb_n;
         frm_err  <= err_n;
      end

   // set-2 {ext, scancode} to Z88 matrix bit index (col*8+row)
   always_comb begin
      idx = '0;
      hit = 1'b1;
      case ({ext, code})
         9'h03D: idx = 6'd0;
         9'h03E: idx = 6'd1;
         9'h031: idx = 6'd2;
         9'h02A: idx = 6'd3;
         9'h022: idx = 6'd4;
         9'h036: idx = 6'd5;
         9'h05A: idx = 6'd6;
         9'h066: idx = 6'd7;
         9'h046: idx = 6'd8;
         9'h03A: idx = 6'd9;
         9'h032: idx = 6'd10;
         9'h021: idx = 6'd11;
         9'h01A: idx = 6'd12;
         9'h02E: idx = 6'd13;
         9'h175: idx = 6'd14;
         9'h05D: idx = 6'd15;
         9'h045: idx = 6'd16;
         9'h04B: idx = 6'd17;
         9'h03B: idx = 6'd18;
         9'h034: idx = 6'd19;
         9'h023: idx = 6'd20;
         9'h025: idx = 6'd21;
         9'h172: idx = 6'd22;
         9'h055: idx = 6'd23;
         9'h01D: idx = 6'd24;
         9'h042: idx = 6'd25;
         9'h033: idx = 6'd26;
         9'h02B: idx = 6'd27;
         9'h01B: idx = 6'd28;
         9'h026: idx = 6'd29;
         9'h174: idx = 6'd30;
         9'h04E: idx = 6'd31;
         9'h04D: idx = 6'd32;
         9'h043: idx = 6'd33;
         9'h035: idx = 6'd34;
         9'h02D: idx = 6'd35;
         9'h01C: idx = 6'd36;
         9'h01E: idx = 6'd37;
         9'h16B: idx = 6'd38;
         9'h05B: idx = 6'd39;
         9'h044: idx = 6'd40;
         9'h03C: idx = 6'd41;
         9'h02C: idx = 6'd42;
         9'h024: idx = 6'd43;
         9'h015: idx = 6'd44;
         9'h016: idx = 6'd45;
         9'h029: idx = 6'd46;
         9'h054: idx = 6'd47;
         9'h052: idx = 6'd48;
         9'h04C: idx = 6'd49;
         9'h041: idx = 6'd50;
         9'h011: idx = 6'd52;
         9'h00D: idx = 6'd53;
         9'h012: idx = 6'd54;
         9'h04A: idx = 6'd57;
         9'h049: idx = 6'd58;
         9'h058: idx = 6'd59;
         9'h014: idx = 6'd60;
         9'h076: idx = 6'd61;
         9'h059: idx = 6'd63;
         default: hit = 1'b0;
      endcase
   end

   // prefix tracking and matrix update, one bit per byte except the clear-all codes
   always_ff @(posedge mck or negedge rin_n)
      if (!rin_n) begin
         kbmat <= '0;
         ext   <= 1'b0;
         brk   <= 1'b0;
      end else if (code_stb) begin
         if (code == 8'hE0)
            ext <= 1'b1;
         else if (code == 8'hF0)
            brk <= 1'b1;
         else begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (code == 8'hAA || code == 8'hFC || code == 8'h00 || code == 8'hFF)
               kbmat <= '0;
            else if (hit)
               kbmat[idx] <= !brk;
         end
      end else if (frm_err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end
endmodule

// File: tb/tb_ps2_kbmat.sv
// tb_ps2_kbmat: randomized PS/2 frames checked against a byte-level key matrix model
module tb_ps2_kbmat;
   logic        mck = 1'b0, rin_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
   logic [63:0] kbmat;
   logic        code_stb, frm_err;
   logic [7:0]  code;
   int          n_chk = 0, n_fail = 0;
   int          stb_cnt = 0, err_cnt = 0;
   int          stb_lat, kb_lat;
   logic [63:0] kb_m = '0;
   bit          ext_m = 0, brk_m = 0;
   int          tbl [bit [8:0]];
   bit [8:0]    keys [$];

   ps2_kbmat dut (.mck(mck), .rin_n(rin_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
                  .kbmat(kbmat), .code_stb(code_stb), .code(code), .frm_err(frm_err));

   always #5 mck = ~mck;

   always @(negedge mck) begin
      if (code_stb) stb_cnt++;
      if (frm_err) err_cnt++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge mck);
   endtask

   function automatic void model_byte(input logic [7:0] b);
      if (b == 8'hE0) ext_m = 1;
      else if (b == 8'hF0) brk_m = 1;
      else begin
         if (b inside {8'hAA, 8'hFC, 8'h00, 8'hFF}) kb_m = '0;
         else if (tbl.exists({ext_m, b})) kb_m[tbl[{ext_m, b}]] = !brk_m;
         ext_m = 0;
         brk_m = 0;
      end
   endfunction

   task automatic send_bit(input bit b, input int hp, input bit glitch);
      ps2_dat = b;
      if (glitch) begin
         wait_cyc(hp / 2);
         ps2_clk = 0;
         wait_cyc(3);
         ps2_clk = 1;
         wait_cyc(hp - hp / 2 - 3);
      end else wait_cyc(hp);
      ps2_clk = 0;
      wait_cyc(hp);
      ps2_clk = 1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
      int hp;
      logic [63:0] kb0;
      hp = $urandom_range(30, 40);
      send_bit(0, hp, 0);
      for (int i = 0; i < 8; i++) send_bit(b[i], hp, glitch);
      send_bit(~^b ^ bad_par, hp, 0);
      ps2_dat = ~bad_stop;
      wait_cyc(hp);
      kb0 = kbmat;
      stb_lat = -1;
      kb_lat = -1;
      ps2_clk = 0;
      for (int i = 1; i <= hp; i++) begin
         @(negedge mck);
         if (code_stb && stb_lat < 0) stb_lat = i;
         if (kbmat !== kb0 && kb_lat < 0) kb_lat = i;
      end
      ps2_clk = 1;
      ps2_dat = 1;
      wait_cyc(hp);
   endtask

   task automatic tx(input logic [7:0] b);
      send_frame(b, 0, 0, 0);
      model_byte(b);
   endtask

   task automatic init_table();
      tbl[9'h03D] = 0;  tbl[9'h03E] = 1;  tbl[9'h031] = 2;  tbl[9'h02A] = 3;
      tbl[9'h022] = 4;  tbl[9'h036] = 5;  tbl[9'h05A] = 6;  tbl[9'h066] = 7;
      tbl[9'h046] = 8;  tbl[9'h03A] = 9;  tbl[9'h032] = 10; tbl[9'h021] = 11;
      tbl[9'h01A] = 12; tbl[9'h02E] = 13; tbl[9'h175] = 14; tbl[9'h05D] = 15;
      tbl[9'h045] = 16; tbl[9'h04B] = 17; tbl[9'h03B] = 18; tbl[9'h034] = 19;
      tbl[9'h023] = 20; tbl[9'h025] = 21; tbl[9'h172] = 22; tbl[9'h055] = 23;
      tbl[9'h01D] = 24; tbl[9'h042] = 25; tbl[9'h033] = 26; tbl[9'h02B] = 27;
      tbl[9'h01B] = 28; tbl[9'h026] = 29; tbl[9'h174] = 30; tbl[9'h04E] = 31;
      tbl[9'h04D] = 32; tbl[9'h043] = 33; tbl[9'h035] = 34; tbl[9'h02D] = 35;
      tbl[9'h01C] = 36; tbl[9'h01E] = 37; tbl[9'h16B] = 38; tbl[9'h05B] = 39;
      tbl[9'h044] = 40; tbl[9'h03C] = 41; tbl[9'h02C] = 42; tbl[9'h024] = 43;
      tbl[9'h015] = 44; tbl[9'h016] = 45; tbl[9'h029] = 46; tbl[9'h054] = 47;
      tbl[9'h052] = 48; tbl[9'h04C] = 49; tbl[9'h041] = 50; tbl[9'h011] = 52;
      tbl[9'h00D] = 53; tbl[9'h012] = 54; tbl[9'h04A] = 57; tbl[9'h049] = 58;
      tbl[9'h058] = 59; tbl[9'h014] = 60; tbl[9'h076] = 61; tbl[9'h059] = 63;
      foreach (tbl[k]) keys.push_back(k);
   endtask

   task automatic test_reset();
      wait_cyc(4);
      n_chk++;
      if ({kbmat, code, code_stb, frm_err} !== 74'd0) begin
         n_fail++;
         $display("FAIL reset_hold: got kbmat=%h code=%h stb=%b err=%b expected all zero", kbmat, code, code_stb, frm_err);
      end
      rin_n = 1;
      wait_cyc(20);
      n_chk++;
      if ({kbmat, code, code_stb, frm_err, stb_cnt, err_cnt} !== {74'd0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_idle: got kbmat=%h code=%h stb_cnt=%0d err_cnt=%0d expected zero", kbmat, code, stb_cnt, err_cnt);
      end
   endtask

   task automatic test_make_break();
      int s0 = stb_cnt;
      tx(8'h1C);
      n_chk++;
      if (kbmat !== 64'd1 << 36) begin n_fail++; $display("FAIL make_a: got %h expected %h", kbmat, 64'd1 << 36); end
      n_chk++;
      if (code !== 8'h1C) begin n_fail++; $display("FAIL code_a: got %h expected 1c", code); end
      n_chk++;
      if (stb_lat !== 11) begin n_fail++; $display("FAIL stb_latency: got %0d expected 11", stb_lat); end
      n_chk++;
      if (kb_lat !== 12) begin n_fail++; $display("FAIL kbmat_latency: got %0d expected 12", kb_lat); end
      tx(8'hF0);
      tx(8'h1C);
      n_chk++;
      if (kbmat !== 64'd0) begin n_fail++; $display("FAIL break_a: got %h expected 0", kbmat); end
      n_chk++;
      if (stb_cnt - s0 !== 3) begin n_fail++; $display("FAIL stb_count_a: got %0d expected 3", stb_cnt - s0); end
   endtask

   task automatic test_ext();
      tx(8'hE0); tx(8'h75);
      n_chk++;
      if (kbmat !== 64'd1 << 14) begin n_fail++; $display("FAIL ext_up_make: got %h expected %h", kbmat, 64'd1 << 14); end
      tx(8'hE0); tx(8'hF0); tx(8'h75);
      n_chk++;
      if (kbmat !== 64'd0) begin n_fail++; $display("FAIL ext_up_break: got %h expected 0", kbmat); end
      tx(8'h29);
      n_chk++;
      if (kbmat !== 64'd1 << 46) begin n_fail++; $display("FAIL ext_no_leak: got %h expected %h", kbmat, 64'd1 << 46); end
   endtask

   task automatic test_parity();
      int s0 = stb_cnt, e0 = err_cnt;
      send_frame(8'h5A, 1, 0, 0);
`ifdef PS2_KBMAT_PARITY_EN
      ext_m = 0; brk_m = 0;
      n_chk++;
      if (err_cnt - e0 !== 1 || stb_cnt - s0 !== 0) begin
         n_fail++; $display("FAIL parity_reject: got err=%0d stb=%0d expected err=1 stb=0", err_cnt - e0, stb_cnt - s0);
      end
      n_chk++;
      if (kbmat[6] !== 1'b0) begin n_fail++; $display("FAIL parity_enter: got %b expected 0", kbmat[6]); end
`else
      model_byte(8'h5A);
      n_chk++;
      if (err_cnt - e0 !== 0 || stb_cnt - s0 !== 1) begin
         n_fail++; $display("FAIL parity_ignored: got err=%0d stb=%0d expected err=0 stb=1", err_cnt - e0, stb_cnt - s0);
      end
      n_chk++;
      if (kbmat[6] !== 1'b1) begin n_fail++; $display("FAIL parity_enter: got %b expected 1", kbmat[6]); end
`endif
      n_chk++;
      if (kbmat !== kb_m) begin n_fail++; $display("FAIL parity_matrix: got %h expected %h", kbmat, kb_m); end
   endtask

   task automatic test_bad_stop();
      int s0, e0;
      tx(8'hE0);
      s0 = stb_cnt; e0 = err_cnt;
      send_frame(8'h75, 0, 1, 0);
      ext_m = 0; brk_m = 0;
      n_chk++;
      if (err_cnt - e0 !== 1 || stb_cnt - s0 !== 0) begin
         n_fail++; $display("FAIL bad_stop: got err=%0d stb=%0d expected err=1 stb=0", err_cnt - e0, stb_cnt - s0);
      end
      tx(8'h75);
      n_chk++;
      if (kbmat !== kb_m || kbmat[14] !== 1'b0) begin n_fail++; $display("FAIL err_clears_ext: got %h expected %h", kbmat, kb_m); end
   endtask

   task automatic test_timeout();
      int s0 = stb_cnt, e0 = err_cnt;
      send_bit(0, 35, 0);
      for (int i = 0; i < 4; i++) send_bit(i[0], 35, 0);
      wait_cyc(19000);
      n_chk++;
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL timeout_early: got err=%0d expected 0", err_cnt - e0); end
      wait_cyc(900);
      ext_m = 0; brk_m = 0;
      n_chk++;
      if (err_cnt - e0 !== 1 || stb_cnt - s0 !== 0) begin
         n_fail++; $display("FAIL timeout_err: got err=%0d stb=%0d expected err=1 stb=0", err_cnt - e0, stb_cnt - s0);
      end
      tx(8'h12);
      n_chk++;
      if (kbmat[54] !== 1'b1 || kbmat !== kb_m) begin n_fail++; $display("FAIL timeout_recover: got %h expected %h", kbmat, kb_m); end
   endtask

   task automatic test_clear();
      tx(8'h12); tx(8'h1C);
      n_chk++;
      if (kbmat[54] !== 1'b1 || kbmat[36] !== 1'b1) begin n_fail++; $display("FAIL held_keys: got %h expected bits 54,36 set", kbmat); end
      tx(8'hAA);
      n_chk++;
      if (kbmat !== 64'd0 || kb_lat !== 12) begin n_fail++; $display("FAIL bat_clear: got %h lat=%0d expected 0 lat=12", kbmat, kb_lat); end
   endtask

   task automatic test_glitch();
      send_frame(8'h29, 0, 0, 1);
      model_byte(8'h29);
      n_chk++;
      if (code !== 8'h29 || kbmat !== kb_m) begin n_fail++; $display("FAIL glitch: got code=%h kbmat=%h expected 29 %h", code, kbmat, kb_m); end
   endtask

   task automatic test_reset_midframe();
      tx(8'h59);
      send_bit(0, 35, 0);
      send_bit(1, 35, 0);
      send_bit(0, 35, 0);
      @(negedge mck);
      #2 rin_n = 0;
      #1;
      n_chk++;
      if ({kbmat, code, code_stb, frm_err} !== 74'd0) begin
         n_fail++; $display("FAIL async_reset: got kbmat=%h code=%h stb=%b err=%b expected all zero", kbmat, code, code_stb, frm_err);
      end
      kb_m = '0; ext_m = 0; brk_m = 0;
      wait_cyc(3);
      rin_n = 1;
      wait_cyc(5);
      tx(8'h1C);
      n_chk++;
      if (kbmat !== 64'd1 << 36) begin n_fail++; $display("FAIL post_reset_frame: got %h expected %h", kbmat, 64'd1 << 36); end
   endtask

   task automatic test_random();
      bit [8:0] k;
      logic [7:0] b;
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 3) == 0) b = 8'h05;
         else begin
            k = keys[$urandom_range(0, keys.size() - 1)];
            if (k[8]) tx(8'hE0);
            if ($urandom_range(0, 2) == 0) tx(8'hF0);
            b = k[7:0];
         end
         tx(b);
         n_chk++;
         if (kbmat !== kb_m || code !== b) begin
            n_fail++; $display("FAIL random_%0d: got kbmat=%h code=%h expected %h %h", n, kbmat, code, kb_m, b);
         end
      end
   endtask

   initial begin
      init_table();
      test_reset();
      test_make_break();
      test_ext();
      test_parity();
      test_bad_stop();
      test_timeout();
      test_clear();
      test_glitch();
      test_random();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
